carry_resolve_16: RTL and testbench

CARRY_RESOLVE_16 -- requirements
Module: carry_resolve_16

---
 rtl/carry_resolve_16.sv | 106 ++++++++++
 tb/tb_carry_resolve_16.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolve_16.sv
// carry_resolve_16
// Resolves a stream of carry-save column pairs (least-significant first) into
// non-redundant binary digits. One digit is produced per column, plus a
// trailing flush digit that carries out whatever remains of the running carry.
module carry_resolve_16 #(
   parameter int DIGIT_W = 16,
   parameter int COL_W   = 19,
   parameter int CARRY_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COL_W-1:0]   in_c,
   input  logic [COL_W-1:0]   in_s,
   input  logic               in_last,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DIGIT_W-1:0] out_digit,
   output logic [7:0]         out_idx,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int SUM_W = COL_W + 2;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [CARRY_W-1:0]   carry_q, carry_d;
   logic [7:0]           cnt_q,   cnt_d;
   logic [DIGIT_W-1:0]   digit_q, digit_d;
   logic [7:0]           idx_q,   idx_d;
   logic                 last_q,  last_d;
   logic                 vld_q,   vld_d;

   logic [SUM_W-1:0]     sum;
   logic                 load_ok;
   logic                 accept;
   logic                 flush_load;

   // The output register can take a new digit when empty or being drained now.
   assign load_ok    = !vld_q || out_ready;
   // rst gates in_ready directly so the block refuses columns while held in reset.
   assign in_ready   = !rst && (state_q == RUN) && load_ok;
   assign accept     = in_valid && in_ready;
   assign flush_load = (state_q == FLUSH) && load_ok;

   assign sum = SUM_W'(in_c) + SUM_W'(in_s) + SUM_W'(carry_q);

   assign out_digit = digit_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign out_valid = vld_q;

   // Next-state: load a column digit in RUN, or the flush digit in FLUSH.
   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      digit_d = digit_q;
      idx_d   = idx_q;
      last_d  = last_q;
      vld_d   = vld_q && !out_ready;
      if (accept) begin
         digit_d = sum[DIGIT_W-1:0];
         idx_d   = cnt_q;
         last_d  = 1'b0;
         vld_d   = 1'b1;
         cnt_d   = cnt_q + 8'd1;
         carry_d = CARRY_W'(sum >> DIGIT_W);
         if (in_last) begin
            state_d = FLUSH;
         end
      end else if (flush_load) begin
         digit_d = DIGIT_W'(carry_q);
         idx_d   = cnt_q;
         last_d  = 1'b1;
         vld_d   = 1'b1;
         cnt_d   = '0;
         carry_d = '0;
         state_d = RUN;
      end
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         carry_q <= '0;
         cnt_q   <= '0;
         digit_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
      end
   end

endmodule

// File: tb/tb_carry_resolve_16.sv
// tb_carry_resolve_16
// Directed bench for carry_resolve_16: hand-computed digit streams, stalls,
// reset during flush, back-to-back frames and a 300-column index wrap.
module tb_carry_resolve_16;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] in_c, in_s;
   logic        in_last, in_valid, in_ready;
   logic [15:0] out_digit;
   logic [7:0]  out_idx;
   logic        out_last, out_valid, out_ready;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc;
   int acc_a;
   logic [24:0] oq[$];

   carry_resolve_16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_c      (in_c),
      .in_s      (in_s),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_digit (out_digit),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output handshake; values are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) oq.push_back({out_last, out_idx, out_digit});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [15:0] d, input logic [7:0] i, input logic l);
      logic [24:0] v;
      if (oq.size() == 0) v = 25'h1FFFFFF;
      else v = oq.pop_front();
      chk(tag, {7'd0, v}, {7'd0, l, i, d});
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [18:0] c, input logic [18:0] s, input logic l);
      int n;
      in_c = c; in_s = s; in_last = l; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", {31'd0, in_ready}, 32'd1);
      acc_cyc = cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_c = '0; in_s = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_digit", {16'd0, out_digit}, 32'd0);
      chk("rst_out_idx",   {24'd0, out_idx},   32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Three-column frame
      out_ready = 1'b1;
      oq.delete();
      send(19'h0FFFF, 19'h00001, 1'b0);
      send(19'h00000, 19'h00000, 1'b0);
      send(19'h7FFFF, 19'h7FFFF, 1'b1);
      idle(5);
      pop_chk("f3_d0", 16'h0000, 8'd0, 1'b0);
      pop_chk("f3_d1", 16'h0001, 8'd1, 1'b0);
      pop_chk("f3_d2", 16'hFFFE, 8'd2, 1'b0);
      pop_chk("f3_flush", 16'h000F, 8'd3, 1'b1);
      chk("f3_count", oq.size(), 32'd0);

      // Output stall for 5 cycles after the first digit
      oq.delete();
      out_ready = 1'b0;
      send(19'h12345, 19'h00001, 1'b0);
      in_c = 19'h0ABCD; in_s = 19'h10000; in_last = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_digit",     {16'd0, out_digit}, 32'h2346);
         chk("stall_idx",       {24'd0, out_idx},   32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(19'h0ABCD, 19'h10000, 1'b0);
      send(19'h00010, 19'h00020, 1'b1);
      idle(5);
      pop_chk("stall_d0", 16'h2346, 8'd0, 1'b0);
      pop_chk("stall_d1", 16'hABCE, 8'd1, 1'b0);
      pop_chk("stall_d2", 16'h0031, 8'd2, 1'b0);
      pop_chk("stall_flush", 16'h0000, 8'd3, 1'b1);
      chk("stall_count", oq.size(), 32'd0);

      // Single-column frame
      oq.delete();
      send(19'h00005, 19'h00003, 1'b1);
      idle(5);
      pop_chk("single_d0", 16'h0008, 8'd0, 1'b0);
      pop_chk("single_flush", 16'h0000, 8'd1, 1'b1);
      chk("single_count", oq.size(), 32'd0);

      // Reset while in FLUSH holding carry=7
      oq.delete();
      out_ready = 1'b0;
      send(19'h70000, 19'h00000, 1'b1);
      idle(1);
      @(negedge clk);
      chk("flush_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("flush_hold_ready", {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      idle(4);
      chk("rst_no_flush", oq.size(), 32'd0);
      send(19'h00001, 19'h00000, 1'b1);
      idle(5);
      pop_chk("after_rst_d0", 16'h0001, 8'd0, 1'b0);
      pop_chk("after_rst_flush", 16'h0000, 8'd1, 1'b1);
      chk("after_rst_count", oq.size(), 32'd0);

      // Back-to-back frames with in_valid held high
      oq.delete();
      send(19'h0FFFF, 19'h0FFFF, 1'b1);
      acc_a = acc_cyc;
      in_c = 19'h00001; in_s = 19'h00000; in_last = 1'b1;
      @(negedge clk);
      chk("b2b_idle_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      send(19'h00001, 19'h00000, 1'b1);
      chk("b2b_gap", acc_cyc - acc_a, 32'd2);
      idle(5);
      pop_chk("b2b_a_d0", 16'hFFFE, 8'd0, 1'b0);
      pop_chk("b2b_a_flush", 16'h0001, 8'd1, 1'b1);
      pop_chk("b2b_b_d0", 16'h0001, 8'd0, 1'b0);
      pop_chk("b2b_b_flush", 16'h0000, 8'd1, 1'b1);
      chk("b2b_count", oq.size(), 32'd0);

      // 300-column frame: 0xFFFFE per column; running carry settles at 0x10
      oq.delete();
      for (int k = 0; k < 300; k++) send(19'h7FFFF, 19'h7FFFF, (k == 299));
      idle(5);
      chk("wrap_count", oq.size(), 32'd301);
      for (int k = 0; k < 301; k++) begin
         logic [15:0] ed;
         if (k == 0) ed = 16'hFFFE;
         else if (k == 1) ed = 16'h000D;
         else if (k == 300) ed = 16'h0010;
         else ed = 16'h000E;
         pop_chk("wrap_digit", ed, 8'(k), (k == 300));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
